// File: rtl/result_assembler_pkg.sv
// Shared calculator package: default datapath widths and the derived-size helpers
// used by the result assembler and its display-side neighbours.
package result_assembler_pkg;

    localparam int DEFAULT_DATA_W = 16;
    localparam int DEFAULT_BEAT_W = 8;

    // Number of result-bus beats that make up one full word.
    function automatic int calc_beats(input int data_w, input int beat_w);
        return data_w / beat_w;
    endfunction

    // History pointer / select width; a single-entry history still needs one bit.
    function automatic int hist_ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // Beat counter width, never narrower than one bit.
    function automatic int beat_cnt_w(input int beats);
        return (beats > 1) ? $clog2(beats) : 1;
    endfunction

endpackage

// File: rtl/result_assembler_abs_conv.sv
// Combinational two's-complement to sign/magnitude converter; also shared with the
// input-echo display path.
module abs_conv #(
    parameter int W      = 16,
    parameter int SIGNED = 1
) (
    input  logic [W-1:0] value,
    output logic [W-1:0] mag,
    output logic         neg
);

    // The most negative value maps to 2^(W-1), which is correct read as unsigned.
    always_comb begin
        if ((SIGNED != 0) && value[W-1]) begin
            neg = 1'b1;
            mag = ~value + W'(1);
        end else begin
            neg = 1'b0;
            mag = value;
        end
    end

endmodule

// File: rtl/result_assembler.sv
// Collects a multi-beat ALU result, commits it as raw and sign/magnitude outputs,
// and keeps a small ring of recent results for ANS/recall.
module result_assembler
    import result_assembler_pkg::*;
#(
    parameter int  DATA_W     = DEFAULT_DATA_W,
    parameter int  BEAT_W     = DEFAULT_BEAT_W,
    parameter int  SIGNED     = 1,
    parameter int  HIST_DEPTH = 4,
    localparam int SEL_W      = hist_ptr_w(HIST_DEPTH),
    localparam int HCNT_W     = $clog2(HIST_DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              finala,
    input  logic              clear,
    input  logic              in_valid,
    input  logic              in_first,
    input  logic [BEAT_W-1:0] in_data,
    output logic [DATA_W-1:0] bin_data,
    output logic [DATA_W-1:0] ans_data,
    output logic              neg,
    output logic              out_valid,
    output logic              partial_drop,
    input  logic [SEL_W-1:0]  hist_sel,
    output logic [DATA_W-1:0] hist_data,
    output logic [HCNT_W-1:0] hist_count
);

    localparam int BEATS    = calc_beats(DATA_W, BEAT_W);
    localparam int CNT_W    = beat_cnt_w(BEATS);
    localparam int SHADOW_W = (BEATS > 1) ? (BEATS - 1) * BEAT_W : BEAT_W;

    localparam logic [CNT_W-1:0]  LAST_IDX  = CNT_W'(BEATS - 1);
    localparam logic [SEL_W-1:0]  PTR_MASK  = SEL_W'(HIST_DEPTH - 1);
    localparam logic [HCNT_W-1:0] HIST_FULL = HCNT_W'(HIST_DEPTH);

    logic [CNT_W-1:0]    cnt_r;
    logic [SHADOW_W-1:0] shadow_r;
    logic [DATA_W-1:0]   hist_r [HIST_DEPTH];
    logic [SEL_W-1:0]    newest_r;

    logic [CNT_W-1:0]    idx_s;
    logic                commit_s;
    logic [DATA_W-1:0]   word_s;
    logic [DATA_W-1:0]   mag_s;
    logic                neg_s;
    logic [SEL_W-1:0]    push_ptr_s;
    logic [SEL_W-1:0]    rd_idx_s;

    // The final beat is never stored in the shadow; it goes straight into the word.
    generate
        if (BEATS > 1) begin : g_multi_beat
            assign word_s = {in_data, shadow_r};
        end else begin : g_single_beat
            assign word_s = in_data;
        end
    endgenerate

    // Slot index of the incoming beat and whether it completes the word.
    always_comb begin
        if (in_first) begin
            idx_s = '0;
        end else begin
            idx_s = cnt_r;
        end
        commit_s = (idx_s == LAST_IDX);
    end

    // Ring pointers wrap by masking; depth is a power of two.
    always_comb begin
        push_ptr_s = (newest_r + SEL_W'(1)) & PTR_MASK;
        rd_idx_s   = (newest_r - hist_sel) & PTR_MASK;
    end

    abs_conv #(
        .W      (DATA_W),
        .SIGNED (SIGNED)
    ) u_abs_conv (
        .value (word_s),
        .mag   (mag_s),
        .neg   (neg_s)
    );

    // Recall read: selections past the valid entries return zero.
    always_comb begin
        if (int'(hist_sel) < int'(hist_count)) begin
            hist_data = hist_r[rd_idx_s];
        end else begin
            hist_data = '0;
        end
    end

    // Beat collection, commit and history push with rst > finala > clear > in_valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r        <= '0;
            shadow_r     <= '0;
            newest_r     <= '0;
            bin_data     <= '0;
            ans_data     <= '0;
            neg          <= 1'b0;
            out_valid    <= 1'b0;
            partial_drop <= 1'b0;
            hist_count   <= '0;
            for (int i = 0; i < HIST_DEPTH; i++) begin
                hist_r[i] <= '0;
            end
        end else if (finala) begin
            out_valid    <= 1'b0;
            partial_drop <= 1'b0;
        end else if (clear) begin
            cnt_r        <= '0;
            out_valid    <= 1'b0;
            partial_drop <= 1'b0;
        end else if (in_valid) begin
            partial_drop <= in_first && (cnt_r != '0);
            for (int b = 0; b < BEATS - 1; b++) begin
                if (idx_s == CNT_W'(b)) begin
                    shadow_r[b*BEAT_W +: BEAT_W] <= in_data;
                end
            end
            if (commit_s) begin
                cnt_r              <= '0;
                bin_data           <= word_s;
                ans_data           <= mag_s;
                neg                <= neg_s;
                out_valid          <= 1'b1;
                hist_r[push_ptr_s] <= word_s;
                newest_r           <= push_ptr_s;
                if (hist_count != HIST_FULL) begin
                    hist_count <= hist_count + HCNT_W'(1);
                end
            end else begin
                cnt_r     <= idx_s + CNT_W'(1);
                out_valid <= 1'b0;
            end
        end else begin
            out_valid    <= 1'b0;
            partial_drop <= 1'b0;
        end
    end

endmodule

// File: tb/tb_result_assembler.sv
// Directed bench for result_assembler: signed default instance plus an unsigned
// instance sharing the same stimulus.
module tb_result_assembler;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        finala = 1'b0;
    logic        clear = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_first = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic [1:0]  hist_sel = 2'd0;

    logic [15:0] bin_data, ans_data, hist_data;
    logic        neg, out_valid, partial_drop;
    logic [2:0]  hist_count;

    logic [15:0] u_bin_data, u_ans_data, u_hist_data;
    logic        u_neg, u_out_valid, u_partial_drop;
    logic [2:0]  u_hist_count;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    result_assembler dut (
        .clk(clk), .rst(rst), .finala(finala), .clear(clear),
        .in_valid(in_valid), .in_first(in_first), .in_data(in_data),
        .bin_data(bin_data), .ans_data(ans_data), .neg(neg),
        .out_valid(out_valid), .partial_drop(partial_drop),
        .hist_sel(hist_sel), .hist_data(hist_data), .hist_count(hist_count)
    );

    result_assembler #(.SIGNED(0)) dut_u (
        .clk(clk), .rst(rst), .finala(finala), .clear(clear),
        .in_valid(in_valid), .in_first(in_first), .in_data(in_data),
        .bin_data(u_bin_data), .ans_data(u_ans_data), .neg(u_neg),
        .out_valid(u_out_valid), .partial_drop(u_partial_drop),
        .hist_sel(hist_sel), .hist_data(u_hist_data), .hist_count(u_hist_count)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One accepted beat; returns #1 after the accepting edge.
    task automatic beat(input logic [7:0] d, input logic first);
        in_valid = 1'b1;
        in_data  = d;
        in_first = first;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_first = 1'b0;
    endtask

    task automatic idle_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_bin", bin_data, 16'h0000);
        check("rst_ans", ans_data, 16'h0000);
        check("rst_neg", neg, 1'b0);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_partial_drop", partial_drop, 1'b0);
        check("rst_hist_count", hist_count, 3'd0);
        check("rst_hist_data", hist_data, 16'h0000);

        // Basic two-beat commit
        beat(8'h34, 1'b1);
        check("b1_no_commit", out_valid, 1'b0);
        beat(8'h12, 1'b0);
        check("b1_bin", bin_data, 16'h1234);
        check("b1_ans", ans_data, 16'h1234);
        check("b1_neg", neg, 1'b0);
        check("b1_out_valid", out_valid, 1'b1);
        check("b1_hist_count", hist_count, 3'd1);
        check("b1_hist0", hist_data, 16'h1234);
        idle_cycle();
        check("b1_pulse_end", out_valid, 1'b0);

        // Most negative value and minus one
        beat(8'h00, 1'b0);
        beat(8'h80, 1'b0);
        check("mneg_bin", bin_data, 16'h8000);
        check("mneg_ans", ans_data, 16'h8000);
        check("mneg_neg", neg, 1'b1);
        check("mneg_u_ans", u_ans_data, 16'h8000);
        check("mneg_u_neg", u_neg, 1'b0);
        beat(8'hFF, 1'b0);
        beat(8'hFF, 1'b0);
        check("m1_bin", bin_data, 16'hFFFF);
        check("m1_ans", ans_data, 16'h0001);
        check("m1_neg", neg, 1'b1);
        check("u_ffff_ans", u_ans_data, 16'hFFFF);
        check("u_ffff_neg", u_neg, 1'b0);

        // Restart with in_first drops the partial word
        beat(8'h11, 1'b0);
        check("drop_none_yet", partial_drop, 1'b0);
        beat(8'h22, 1'b1);
        check("drop_pulse", partial_drop, 1'b1);
        check("drop_no_commit", out_valid, 1'b0);
        beat(8'h33, 1'b0);
        check("drop_pulse_end", partial_drop, 1'b0);
        check("drop_bin", bin_data, 16'h3322);

        // Hold freezes everything, collection resumes afterwards
        beat(8'h11, 1'b0);
        finala   = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'hEE;
        for (int i = 0; i < 5; i++) begin
            idle_cycle();
            check("hold_no_commit", out_valid, 1'b0);
            check("hold_bin", bin_data, 16'h3322);
        end
        finala   = 1'b0;
        in_valid = 1'b0;
        beat(8'h44, 1'b0);
        check("hold_bin_after", bin_data, 16'h4411);
        check("hold_commit", out_valid, 1'b1);

        // History saturation and recall order
        for (int w = 0; w < 5; w++) begin
            beat(8'hA0 + 8'(w), 1'b0);
            beat(8'h0A + 8'(w), 1'b0);
        end
        check("hist_count_sat", hist_count, 3'd4);
        hist_sel = 2'd0; #1;
        check("hist_sel0", hist_data, 16'h0EA4);
        hist_sel = 2'd1; #1;
        check("hist_sel1", hist_data, 16'h0DA3);
        hist_sel = 2'd2; #1;
        check("hist_sel2", hist_data, 16'h0CA2);
        hist_sel = 2'd3; #1;
        check("hist_sel3", hist_data, 16'h0BA1);
        hist_sel = 2'd0;

        // Clear discards the partial word and ignores that cycle's beat
        beat(8'h55, 1'b0);
        clear    = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'h66;
        idle_cycle();
        clear    = 1'b0;
        in_valid = 1'b0;
        check("clear_no_commit", out_valid, 1'b0);
        check("clear_no_drop", partial_drop, 1'b0);
        beat(8'h77, 1'b0);
        beat(8'h88, 1'b0);
        check("clear_bin", bin_data, 16'h8877);
        check("clear_ans", ans_data, 16'h7789);

        // Reset mid-collection
        beat(8'h99, 1'b0);
        rst = 1'b1;
        idle_cycle();
        rst = 1'b0;
        check("rst2_hist_count", hist_count, 3'd0);
        check("rst2_bin", bin_data, 16'h0000);
        beat(8'h01, 1'b0);
        check("rst2_first_beat", out_valid, 1'b0);
        beat(8'h02, 1'b0);
        check("rst2_bin_after", bin_data, 16'h0201);
        check("rst2_hist_count1", hist_count, 3'd1);
        check("rst2_hist0", hist_data, 16'h0201);
        hist_sel = 2'd1; #1;
        check("rst2_hist1_empty", hist_data, 16'h0000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
